// File: rtl/mmio_io_ctrl_pkg.sv
// Shared definitions for the board I/O slave: register offsets, register
// select encoding and the hex-to-7-segment pattern table.
// Combinational helpers only; no latency, no flow control.
package mmio_io_ctrl_pkg;

  // Byte offsets inside the I/O window
  localparam logic [4:0] IO_SW   = 5'h00;
  localparam logic [4:0] IO_BTN  = 5'h04;
  localparam logic [4:0] IO_LED  = 5'h08;
  localparam logic [4:0] IO_SEG  = 5'h0C;
  localparam logic [4:0] IO_SCTL = 5'h10;

  typedef enum logic [2:0] {
    REG_SW,
    REG_BTN,
    REG_LED,
    REG_SEG,
    REG_SCTL,
    REG_NONE
  } io_reg_e;

  // Decode a word index (offset[4:2]) into a register select
  function automatic io_reg_e decode_reg(input logic [2:0] word_idx);
    io_reg_e sel;
    sel = REG_NONE;
    if (word_idx == IO_SW[4:2])   sel = REG_SW;
    if (word_idx == IO_BTN[4:2])  sel = REG_BTN;
    if (word_idx == IO_LED[4:2])  sel = REG_LED;
    if (word_idx == IO_SEG[4:2])  sel = REG_SEG;
    if (word_idx == IO_SCTL[4:2]) sel = REG_SCTL;
    return sel;
  endfunction

  // Active-low segment pattern {dp,g,f,e,d,c,b,a}, dp always off
  function automatic logic [7:0] hex7seg(input logic [3:0] nib);
    logic [7:0] pat;
    case (nib)
      4'h0: pat = 8'hC0;
      4'h1: pat = 8'hF9;
      4'h2: pat = 8'hA4;
      4'h3: pat = 8'hB0;
      4'h4: pat = 8'h99;
      4'h5: pat = 8'h92;
      4'h6: pat = 8'h82;
      4'h7: pat = 8'hF8;
      4'h8: pat = 8'h80;
      4'h9: pat = 8'h90;
      4'hA: pat = 8'h88;
      4'hB: pat = 8'h83;
      4'hC: pat = 8'hC6;
      4'hD: pat = 8'hA1;
      4'hE: pat = 8'h86;
      default: pat = 8'h8E;
    endcase
    return pat;
  endfunction

endpackage

// File: rtl/mmio_io_ctrl_debounce.sv
// Push-button conditioner: 2-flop synchroniser, stability counter, debounced level, rising-edge pulse.
// Latency: 2 sync cycles + DEBOUNCE_CYCLES stable cycles before btn_db follows the button.
// Backpressure: none; free-running, the pulse is a single cycle and must be captured by the caller.
// Ports: clk, rst (sync, active-high), button (raw async) -> btn_db (level), btn_rise (1-cycle pulse,
//        coincident with the edge on which btn_db goes 0->1).
module io_debounce #(
  parameter int DEBOUNCE_CYCLES = 20000
) (
  input  logic clk,
  input  logic rst,
  input  logic button,
  output logic btn_db,
  output logic btn_rise
);

  localparam int CW = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;

  logic          btn_meta;
  logic          btn_sync;
  logic [CW-1:0] cnt;
  logic          cnt_done;

  assign cnt_done = (cnt == CW'(DEBOUNCE_CYCLES - 1));

  // Counter only runs while the synchronised input disagrees with the
  // debounced level; any bounce back to agreement restarts it.
  always_ff @(posedge clk) begin
    if (rst) begin
      btn_meta <= 1'b0;
      btn_sync <= 1'b0;
      btn_db   <= 1'b0;
      cnt      <= '0;
    end else begin
      btn_meta <= button;
      btn_sync <= btn_meta;
      if (btn_sync == btn_db) begin
        cnt <= '0;
      end else if (cnt_done) begin
        cnt    <= '0;
        btn_db <= btn_sync;
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end

  assign btn_rise = btn_sync & ~btn_db & cnt_done;

endmodule

// File: rtl/mmio_io_ctrl.sv
// Memory-mapped board I/O slave: switches, debounced button with sticky press flag, LEDs, 8-digit 7-seg scan.
// Latency: read data/valid registered, one cycle after io_re; writes visible the cycle after io_we.
// Backpressure: none; every access is accepted, io_re together with io_we is a write only.
// Ports: clk, rst | io_re, io_we, io_addr[4:0], io_wdata[31:0] -> io_rdata[31:0], io_rvalid
//        switches[15:0], button (raw) | LED[15:0], seg_an[7:0], seg_cat[7:0] (active-low)
module mmio_io_ctrl #(
  parameter int DEBOUNCE_CYCLES = 20000,
  parameter int SCAN_DIV        = 50000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        io_re,
  input  logic        io_we,
  input  logic [4:0]  io_addr,
  input  logic [31:0] io_wdata,
  output logic [31:0] io_rdata,
  output logic        io_rvalid,
  input  logic [15:0] switches,
  input  logic        button,
  output logic [15:0] LED,
  output logic [7:0]  seg_an,
  output logic [7:0]  seg_cat
);

  import mmio_io_ctrl_pkg::*;

  localparam int DW = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;

  logic [15:0]   sw_meta;
  logic [15:0]   sw_sync;
  logic [15:0]   led_reg;
  logic [31:0]   seg_reg;
  logic          seg_en;
  logic          btn_db;
  logic          btn_rise;
  logic          btn_flag;
  logic          wr_en;
  logic          rd_en;
  io_reg_e       reg_sel;
  logic [31:0]   rd_mux;
  logic [DW-1:0] div_cnt;
  logic [2:0]    digit_idx;
  logic          addr_lsb_unused;

  // Word-aligned window: byte lanes are not decoded
  assign addr_lsb_unused = ^io_addr[1:0];

  assign reg_sel = decode_reg(io_addr[4:2]);
  assign wr_en   = io_we;
  assign rd_en   = io_re & ~io_we;

  always_ff @(posedge clk) begin
    if (rst) begin
      sw_meta <= '0;
      sw_sync <= '0;
    end else begin
      sw_meta <= switches;
      sw_sync <= sw_meta;
    end
  end

  io_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_debounce (
    .clk     (clk),
    .rst     (rst),
    .button  (button),
    .btn_db  (btn_db),
    .btn_rise(btn_rise)
  );

  // Writable registers; RO and unmapped offsets fall through to default
  always_ff @(posedge clk) begin
    if (rst) begin
      led_reg <= '0;
      seg_reg <= '0;
      seg_en  <= 1'b0;
    end else if (wr_en) begin
      case (reg_sel)
        REG_LED:  led_reg <= io_wdata[15:0];
        REG_SEG:  seg_reg <= io_wdata;
        REG_SCTL: seg_en  <= io_wdata[0];
        default:  ;
      endcase
    end
  end

  // Sticky press flag: a new press beats a clearing read in the same cycle,
  // so no press can be lost between the read sampling and the clear.
  always_ff @(posedge clk) begin
    if (rst) begin
      btn_flag <= 1'b0;
    end else if (btn_rise) begin
      btn_flag <= 1'b1;
    end else if (rd_en && (reg_sel == REG_BTN)) begin
      btn_flag <= 1'b0;
    end
  end

  always_comb begin
    rd_mux = '0;
    case (reg_sel)
      REG_SW:   rd_mux = {16'b0, sw_sync};
      REG_BTN:  rd_mux = {30'b0, btn_flag, btn_db};
      REG_LED:  rd_mux = {16'b0, led_reg};
      REG_SEG:  rd_mux = seg_reg;
      REG_SCTL: rd_mux = {31'b0, seg_en};
      default:  rd_mux = '0;
    endcase
  end

  // io_rdata only moves on an accepted read so it holds between reads
  always_ff @(posedge clk) begin
    if (rst) begin
      io_rdata  <= '0;
      io_rvalid <= 1'b0;
    end else begin
      io_rvalid <= rd_en;
      if (rd_en) io_rdata <= rd_mux;
    end
  end

  // Scanner counters run regardless of seg_en
  always_ff @(posedge clk) begin
    if (rst) begin
      div_cnt   <= '0;
      digit_idx <= '0;
    end else if (div_cnt == DW'(SCAN_DIV - 1)) begin
      div_cnt   <= '0;
      digit_idx <= digit_idx + 3'd1;
    end else begin
      div_cnt <= div_cnt + DW'(1);
    end
  end

  // Registered drive: outputs follow digit_idx one cycle later
  always_ff @(posedge clk) begin
    if (rst) begin
      seg_an  <= 8'hFF;
      seg_cat <= 8'hFF;
    end else if (seg_en) begin
      seg_an  <= ~(8'h01 << digit_idx);
      seg_cat <= hex7seg(seg_reg[{digit_idx, 2'b00} +: 4]);
    end else begin
      seg_an  <= 8'hFF;
      seg_cat <= 8'hFF;
    end
  end

  assign LED = led_reg;

endmodule

// File: tb/tb_mmio_io_ctrl.sv
// Directed bench for mmio_io_ctrl with DEBOUNCE_CYCLES=4, SCAN_DIV=3.
// Inputs change 1 time unit after a rising edge; outputs are sampled there too.
// A register-access vector table is followed by hand-written multi-cycle sequences.
module tb_mmio_io_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        io_re;
  logic        io_we;
  logic [4:0]  io_addr;
  logic [31:0] io_wdata;
  logic [31:0] io_rdata;
  logic        io_rvalid;
  logic [15:0] switches;
  logic        button;
  logic [15:0] LED;
  logic [7:0]  seg_an;
  logic [7:0]  seg_cat;

  int total = 0;
  int bad   = 0;

  mmio_io_ctrl #(
    .DEBOUNCE_CYCLES(4),
    .SCAN_DIV       (3)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .io_re    (io_re),
    .io_we    (io_we),
    .io_addr  (io_addr),
    .io_wdata (io_wdata),
    .io_rdata (io_rdata),
    .io_rvalid(io_rvalid),
    .switches (switches),
    .button   (button),
    .LED      (LED),
    .seg_an   (seg_an),
    .seg_cat  (seg_cat)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        re;
    logic        we;
    logic [4:0]  addr;
    logic [31:0] wdata;
    logic        exp_rvalid;
    logic [31:0] exp_rdata;
    logic [15:0] exp_led;
  } vec_t;

  localparam int NVEC = 19;
  vec_t vecs [NVEC];

  function automatic vec_t mk(input logic re, input logic we, input logic [4:0] addr,
                              input logic [31:0] wdata, input logic exp_rvalid,
                              input logic [31:0] exp_rdata, input logic [15:0] exp_led);
    vec_t v;
    v.re = re; v.we = we; v.addr = addr; v.wdata = wdata;
    v.exp_rvalid = exp_rvalid; v.exp_rdata = exp_rdata; v.exp_led = exp_led;
    return v;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic idle();
    io_re = 1'b0; io_we = 1'b0; io_addr = 5'h00; io_wdata = 32'h0;
  endtask

  initial begin
    int n;
    logic [7:0] exp_an;

    //          re  we  addr   wdata         rvalid rdata         LED
    vecs[0]  = mk(1, 0, 5'h0C, 32'h0,        1, 32'h0,        16'h0);
    vecs[1]  = mk(1, 0, 5'h00, 32'h0,        1, 32'h0000A5C3, 16'h0);
    vecs[2]  = mk(0, 1, 5'h08, 32'h1234,     0, 32'h0000A5C3, 16'h1234);
    vecs[3]  = mk(1, 0, 5'h08, 32'h0,        1, 32'h00001234, 16'h1234);
    vecs[4]  = mk(0, 1, 5'h0C, 32'h76543210, 0, 32'h00001234, 16'h1234);
    vecs[5]  = mk(1, 0, 5'h0C, 32'h0,        1, 32'h76543210, 16'h1234);
    vecs[6]  = mk(1, 1, 5'h08, 32'hFFFF,     0, 32'h76543210, 16'hFFFF);
    vecs[7]  = mk(1, 0, 5'h14, 32'h0,        1, 32'h0,        16'hFFFF);
    vecs[8]  = mk(0, 1, 5'h00, 32'hDEAD,     0, 32'h0,        16'hFFFF);
    vecs[9]  = mk(1, 0, 5'h00, 32'h0,        1, 32'h0000A5C3, 16'hFFFF);
    vecs[10] = mk(0, 1, 5'h04, 32'h3,        0, 32'h0000A5C3, 16'hFFFF);
    vecs[11] = mk(1, 0, 5'h04, 32'h0,        1, 32'h0,        16'hFFFF);
    vecs[12] = mk(0, 0, 5'h08, 32'h0,        0, 32'h0,        16'hFFFF);
    vecs[13] = mk(0, 1, 5'h10, 32'h1,        0, 32'h0,        16'hFFFF);
    vecs[14] = mk(1, 0, 5'h10, 32'h0,        1, 32'h1,        16'hFFFF);
    vecs[15] = mk(1, 0, 5'h1C, 32'h0,        1, 32'h0,        16'hFFFF);
    vecs[16] = mk(1, 0, 5'h0A, 32'h0,        1, 32'h0000FFFF, 16'hFFFF);
    vecs[17] = mk(0, 1, 5'h08, 32'h000100AB, 0, 32'h0000FFFF, 16'h00AB);
    vecs[18] = mk(1, 0, 5'h08, 32'h0,        1, 32'h000000AB, 16'h00AB);

    // Reset held two cycles
    rst = 1'b1; switches = 16'h0; button = 1'b0;
    idle();
    step();
    step();
    check("rst_rdata",   io_rdata,  32'h0);
    check("rst_rvalid",  {31'b0, io_rvalid}, 32'h0);
    check("rst_led",     {16'b0, LED},     32'h0);
    check("rst_seg_an",  {24'b0, seg_an},  32'hFF);
    check("rst_seg_cat", {24'b0, seg_cat}, 32'hFF);
    rst = 1'b0;

    // Let the switch synchroniser settle before the register table
    switches = 16'hA5C3;
    step();
    step();

    for (int i = 0; i < NVEC; i++) begin
      io_re = vecs[i].re; io_we = vecs[i].we;
      io_addr = vecs[i].addr; io_wdata = vecs[i].wdata;
      step();
      check($sformatf("vec%0d_rvalid", i), {31'b0, io_rvalid}, {31'b0, vecs[i].exp_rvalid});
      check($sformatf("vec%0d_rdata", i),  io_rdata, vecs[i].exp_rdata);
      check($sformatf("vec%0d_led", i),    {16'b0, LED}, {16'b0, vecs[i].exp_led});
    end
    idle();

    // Scanner: SEG=76543210 and seg_en=1 from the table. Align on the 7F->FE step.
    n = 0;
    while (seg_an !== 8'h7F && n < 100) begin step(); n++; end
    check("scan_find_7F", {24'b0, seg_an}, 32'h7F);
    n = 0;
    while (seg_an !== 8'hFE && n < 100) begin step(); n++; end
    check("scan_find_FE", {24'b0, seg_an}, 32'hFE);
    check("scan_cat_d0", {24'b0, seg_cat}, 32'hC0);
    for (int k = 1; k < 27; k++) begin
      step();
      exp_an = 8'h01 << ((k / 3) % 8);
      exp_an = ~exp_an;
      check($sformatf("scan_an_k%0d", k), {24'b0, seg_an}, {24'b0, exp_an});
      if (k == 3) check("scan_cat_d1", {24'b0, seg_cat}, 32'hF9);
      if (k == 6) check("scan_cat_d2", {24'b0, seg_cat}, 32'hA4);
    end

    // Blanking: seg_en=0 forces anodes off
    io_we = 1'b1; io_addr = 5'h10; io_wdata = 32'h0;
    step();
    idle();
    step();
    check("blank_an",  {24'b0, seg_an},  32'hFF);
    check("blank_cat", {24'b0, seg_cat}, 32'hFF);

    // Switch change appears in a read issued two cycles later
    switches = 16'h5A3C;
    io_re = 1'b1; io_addr = 5'h00;
    step();
    check("sw_lag1", io_rdata, 32'h0000A5C3);
    step();
    check("sw_lag2", io_rdata, 32'h0000A5C3);
    step();
    check("sw_new",  io_rdata, 32'h00005A3C);
    idle();
    step();

    // Bounce 1,0,1,0 one cycle each, then hold 1. btn_db rises on the 6th
    // edge of the hold; a BTN read on that same edge sees the old state.
    button = 1'b1; step();
    button = 1'b0; step();
    button = 1'b1; step();
    button = 1'b0; step();
    button = 1'b1;
    for (int e = 1; e <= 4; e++) step();
    io_re = 1'b1; io_addr = 5'h04;
    step();   // edge 5
    check("btn_e5",        io_rdata, 32'h0);
    step();   // edge 6: flag set and read clear collide
    check("btn_e6_rvalid", {31'b0, io_rvalid}, 32'h1);
    check("btn_e6_race",   io_rdata, 32'h0);
    step();   // edge 7
    check("btn_first",     io_rdata, 32'h3);
    step();   // edge 8
    check("btn_second",    io_rdata, 32'h1);
    idle();
    step();
    check("btn_rvalid_lo", {31'b0, io_rvalid}, 32'h0);
    check("btn_rdata_hold", io_rdata, 32'h1);

    // Reset arriving with a read: the access is dropped
    io_re = 1'b1; io_addr = 5'h08;
    rst = 1'b1;
    step();
    check("rstrd_rvalid", {31'b0, io_rvalid}, 32'h0);
    check("rstrd_rdata",  io_rdata, 32'h0);
    check("rstrd_led",    {16'b0, LED}, 32'h0);
    rst = 1'b0;
    idle();
    step();
    check("rstrd_lost",   {31'b0, io_rvalid}, 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
